// File: rtl/bus_seq_checker.sv
// Packet sequence checker: validates a fixed all-ones header and an incrementing
// sequence number. Define BUS_SEQ_ERR_COUNT_EN to build the saturating error-entry counter.
module bus_seq_checker #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BUS_SIZE-1:0]            data_in,
  input  logic                           valid_in,
  output logic [BUS_SIZE-1:0]            data_out,
  output logic                           valid_out,
  output logic [BUS_SIZE/WORD_SIZE-1:0]  control_out,
  output logic [4:0]                     state,
  output logic [4:0]                     next_state,
  output logic                           error,
  output logic [CNT_WIDTH-1:0]           err_count
);

  localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] SEQ_ONE = WORD_SIZE'(1);

  typedef enum logic [4:0] {
    RESET     = 5'b00001,
    FIRST_PKT = 5'b00010,
    REG_PKT   = 5'b00100,
    F_ERR     = 5'b01000,
    SEQ_ERR   = 5'b10000
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_SIZE-1:0]  expected_q, expected_d;
  logic [WORD_SIZE-1:0]  seq_num;
  logic                  hdr_good;
  logic                  seq_zero;
  logic                  seq_match;
  logic                  accept;
  logic                  next_is_err;
  logic [WORD_NUM-1:0]   control_d;

  assign hdr_good  = &data_in[BUS_SIZE-1 -: WORD_SIZE];
  assign seq_num   = data_in[WORD_SIZE-1:0];
  assign seq_zero  = (seq_num == '0);
  assign seq_match = (seq_num == expected_q);

  always_comb begin
    control_d = '0;
    for (int i = 0; i < WORD_NUM; i++) begin
      control_d[i] = |data_in[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Header errors take priority over sequence errors; error states only
  // resync on a good header carrying sequence number zero.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    case (state_q)
      RESET: begin
        state_d = FIRST_PKT;
      end
      FIRST_PKT: begin
        if (valid_in) begin
          if (!hdr_good) begin
            state_d = F_ERR;
          end else if (seq_zero) begin
            state_d    = REG_PKT;
            expected_d = SEQ_ONE;
          end else begin
            state_d = SEQ_ERR;
          end
        end
      end
      REG_PKT: begin
        if (valid_in) begin
          if (!hdr_good) begin
            state_d = F_ERR;
          end else if (seq_match) begin
            expected_d = expected_q + SEQ_ONE;
          end else begin
            state_d = SEQ_ERR;
          end
        end
      end
      F_ERR, SEQ_ERR: begin
        if (valid_in && hdr_good && seq_zero) begin
          state_d    = REG_PKT;
          expected_d = SEQ_ONE;
        end
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  assign accept      = valid_in && (state_d == REG_PKT);
  assign next_is_err = (state_d == F_ERR) || (state_d == SEQ_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      control_out <= '0;
      valid_out   <= 1'b0;
      error       <= 1'b0;
    end else begin
      valid_out <= accept;
      error     <= next_is_err;
      if (accept) begin
        data_out    <= data_in;
        control_out <= control_d;
      end
    end
  end

`ifdef BUS_SEQ_ERR_COUNT_EN
  logic                 cur_is_err;
  logic                 enter_err;
  logic [CNT_WIDTH-1:0] err_count_q;

  assign cur_is_err = (state_q == F_ERR) || (state_q == SEQ_ERR);
  assign enter_err  = next_is_err && !cur_is_err;

  // Counts entries into the error states only, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (enter_err && !(&err_count_q)) begin
      err_count_q <= err_count_q + CNT_WIDTH'(1);
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign state      = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_bus_seq_checker.sv
// Scoreboard bench for bus_seq_checker (BUS_SIZE=16, WORD_SIZE=4): directed packets,
// expected accepted packets queued at stimulus time and popped by a valid_out monitor.
module tb_bus_seq_checker;

  localparam logic [4:0] S_RESET = 5'b00001;
  localparam logic [4:0] S_FIRST = 5'b00010;
  localparam logic [4:0] S_REG   = 5'b00100;
  localparam logic [4:0] S_FERR  = 5'b01000;
  localparam logic [4:0] S_SERR  = 5'b10000;

`ifdef BUS_SEQ_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        valid_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic [3:0]  control_out;
  logic [4:0]  state;
  logic [4:0]  next_state;
  logic        error;
  logic [7:0]  err_count;

  bus_seq_checker #(.BUS_SIZE(16), .WORD_SIZE(4), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .control_out(control_out),
    .state      (state),
    .next_state (next_state),
    .error      (error),
    .err_count  (err_count)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  ctrl;
  } sb_t;

  sb_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [4:0]  m_state;
  logic [3:0]  m_exp;
  int          m_cnt;
  logic        m_valid;
  logic        m_err;
  logic [15:0] m_data;
  logic [3:0]  m_ctrl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_state = S_RESET;
    m_exp   = 4'd0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_data  = 16'h0;
    m_ctrl  = 4'h0;
  endtask

  task automatic checkOutput();
    compareVal("state", {27'b0, state}, {27'b0, m_state});
    compareVal("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    compareVal("error", {31'b0, error}, {31'b0, m_err});
    compareVal("err_count", {24'b0, err_count}, m_cnt);
    compareVal("data_out_hold", {16'b0, data_out}, {16'b0, m_data});
    compareVal("control_out_hold", {28'b0, control_out}, {28'b0, m_ctrl});
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d);
    logic [4:0] nxt;
    logic [3:0] nexp;
    logic       hdr;
    logic [3:0] sq;
    logic       acc;
    logic [3:0] ctl;
    sb_t        ent;
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    hdr  = (d[15:12] == 4'hF);
    sq   = d[3:0];
    nxt  = m_state;
    nexp = m_exp;
    case (m_state)
      S_RESET: nxt = S_FIRST;
      S_FIRST: if (v) begin
        if (!hdr) nxt = S_FERR;
        else if (sq == 4'd0) begin nxt = S_REG; nexp = 4'd1; end
        else nxt = S_SERR;
      end
      S_REG: if (v) begin
        if (!hdr) nxt = S_FERR;
        else if (sq == m_exp) nexp = m_exp + 4'd1;
        else nxt = S_SERR;
      end
      default: if (v && hdr && sq == 4'd0) begin nxt = S_REG; nexp = 4'd1; end
    endcase
    acc = v && (nxt == S_REG);
    for (int i = 0; i < 4; i++) ctl[i] = (d[i*4 +: 4] != 4'd0);
    #1;
    compareVal("next_state", {27'b0, next_state}, {27'b0, nxt});
    if (acc) begin
      ent.data = d;
      ent.ctrl = ctl;
      sb_q.push_back(ent);
      m_data = d;
      m_ctrl = ctl;
    end
    if (CNT_EN && (nxt == S_FERR || nxt == S_SERR) && !(m_state == S_FERR || m_state == S_SERR)
        && m_cnt < 255)
      m_cnt++;
    m_valid = acc;
    m_err   = (nxt == S_FERR || nxt == S_SERR);
    m_state = nxt;
    m_exp   = nexp;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic doReset();
    @(negedge clk);
    #2;
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (valid_out) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL scoreboard_unexpected: got data_out=%h with nothing expected", data_out);
      end else begin
        e = sb_q.pop_front();
        if (data_out !== e.data || control_out !== e.ctrl) begin
          bad++;
          $display("[TB] FAIL scoreboard_pkt: got %h/%b expected %h/%b",
                   data_out, control_out, e.data, e.ctrl);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 16'h0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #3;
    reset = 1'b0;

    $display("[TB] basic accept");
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b1, 16'hF001);
    applyStimulus(1'b1, 16'hF002);

    $display("[TB] idle gap");
    doReset();
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b0, 16'hF005);
    applyStimulus(1'b0, 16'hE001);
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF001);

    $display("[TB] sequence wrap");
    doReset();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'hF000 | 16'(i));
    applyStimulus(1'b1, 16'hF000);

    $display("[TB] header error and resync");
    doReset();
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b1, 16'hE001);
    applyStimulus(1'b1, 16'hF005);
    applyStimulus(1'b1, 16'hF000);

    $display("[TB] sequence error");
    doReset();
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b1, 16'hF001);
    applyStimulus(1'b1, 16'hF003);
    applyStimulus(1'b1, 16'hE003);

    $display("[TB] reset mid stream");
    doReset();
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF000);
    applyStimulus(1'b1, 16'hF001);
    doReset();
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hF004);
    applyStimulus(1'b0, 16'h0000);

    @(negedge clk);
    @(negedge clk);
    compareVal("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_seq_checker.md
BUS_SEQ_CHECKER -- requirements
Module: bus_seq_checker

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 16, input bus width in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 4, word width in bits; WORD_NUM = BUS_SIZE/WORD_SIZE is derived, not overridable.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, error-counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port data_in, input, BUS_SIZE, packet; word WORD_NUM-1 is the header, word 0 is the sequence number.
REQ-007 SHALL have port valid_in, input, 1, data_in holds a packet this cycle.
REQ-008 SHALL have port data_out, output, BUS_SIZE, registered copy of the last accepted packet.
REQ-009 SHALL have port valid_out, output, 1, single-cycle pulse, data_out updated.
REQ-010 SHALL have port control_out, output, WORD_NUM, bit i = word i of the accepted packet is nonzero.
REQ-011 SHALL have port state, output, 5, registered one-hot state.
REQ-012 SHALL have port next_state, output, 5, combinational next state.
REQ-013 SHALL have port error, output, 1, registered; high while state is F_ERR or SEQ_ERR.
REQ-014 SHALL have port err_count, output, CNT_WIDTH, error-entry count (see Configuration).

Function
REQ-015 SHALL encode states as RESET=5'b00001, FIRST_PKT=5'b00010, REG_PKT=5'b00100, F_ERR=5'b01000, SEQ_ERR=5'b10000.
REQ-016 SHALL define the header as good when word WORD_NUM-1 is all ones; the sequence number is word 0 as unsigned modulo 2^WORD_SIZE.
REQ-017 SHALL leave state and the expected-sequence register unchanged in every cycle with valid_in low, except RESET->FIRST_PKT.
REQ-018 SHALL move RESET to FIRST_PKT on the first clock edge after reset deassertion, regardless of valid_in.
REQ-019 SHALL, in FIRST_PKT with valid_in, go to REG_PKT with expected=1 on good header and seq==0; to F_ERR on bad header; otherwise to SEQ_ERR.
REQ-020 SHALL, in REG_PKT with valid_in, stay on good header and seq==expected, incrementing expected with wrap from 2^WORD_SIZE-1 to 0; go to F_ERR on bad header; otherwise go to SEQ_ERR.
REQ-021 SHALL give header checking priority over sequence checking when both fail (F_ERR).
REQ-022 SHALL, in F_ERR or SEQ_ERR with valid_in, resync to REG_PKT with expected=1 only on good header and seq==0; any other packet leaves the state unchanged.
REQ-023 SHALL accept a packet only when its transition lands in REG_PKT; next cycle data_out=data_in, control_out per REQ-010, valid_out=1.
REQ-024 SHALL hold data_out and control_out and drive valid_out=0 in all cycles without an accepted packet.
REQ-025 SHALL give one-cycle latency from an accepting clock edge to valid_out and error.

Reset
REQ-026 SHALL, while reset is high, asynchronously force state=RESET, expected=0, data_out=0, control_out=0, valid_out=0, error=0, err_count=0.
REQ-027 SHALL, on reset mid-packet-stream, discard all history; the next packet after reset release plus one edge is checked as the first packet.

Configuration
REQ-028 SHALL, with macro BUS_SEQ_ERR_COUNT_EN defined, increment err_count on each transition from a non-error state into F_ERR or SEQ_ERR, saturating at all ones; staying in or moving between error states does not count.
REQ-029 SHALL, without BUS_SEQ_ERR_COUNT_EN, tie err_count to 0 and instantiate no counter flops.

Verification (BUS_SIZE=16, WORD_SIZE=4)
REQ-030 SHALL cover: reset then valid F000,F001,F002 -> states FIRST_PKT,REG_PKT,REG_PKT; valid_out pulses; data_out F000/F001/F002; control_out 1000,1001,1001; error=0.
REQ-031 SHALL cover: 17 good packets F000..F00F,F000 -> all accepted, wrap without error.
REQ-032 SHALL cover: after F000, send E001 -> F_ERR, error=1, valid_out=0, err_count=1; then F005 -> stays F_ERR; then F000 -> REG_PKT, accepted, error=0.
REQ-033 SHALL cover: after F000,F001, send F003 -> SEQ_ERR, err_count=1; then E003 -> stays SEQ_ERR, err_count stays 1.
REQ-034 SHALL cover: reset asserted between clock edges during REG_PKT -> outputs zero immediately; after release F004 -> SEQ_ERR.
REQ-035 SHALL cover: with valid_in low between F000 and F001 for 3 cycles -> no state change, no error; without BUS_SEQ_ERR_COUNT_EN rerun REQ-032 -> err_count=0.
